paddsb_seq: RTL and testbench

- Area-reduced, multi-cycle implementation of the packed saturating nibble add (PADDSB).
- One shared 4-bit saturating adder lane is time-multiplexed across all nibbles of a 16-bit operand pair, sequenced by a small FSM.
- Sits beside the ALU as an optional long-latency functional unit, with valid/ready handshakes on both the operand side and the result side.

---
 rtl/paddsb_pkg.sv | 19 +
 rtl/paddsb_seq_sat_lane_add.sv | 23 ++
 rtl/paddsb_seq.sv | 113 +++++++++++
 tb/tb_paddsb_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/paddsb_pkg.sv
// Shared definitions for the sequential packed saturating nibble adder.
package paddsb_pkg;

  localparam int LANE_W = 4;
  localparam int LANES  = 4;
  localparam int DW     = LANE_W * LANES;
  localparam int CNT_W  = $clog2(LANES);

  // Clamp values for a signed LANE_W-bit lane.
  localparam logic [LANE_W-1:0] SAT_POS = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_NEG = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/paddsb_seq_sat_lane_add.sv
// One signed LANE_W-bit add with saturation; shared across all lanes.
module sat_lane_add
  import paddsb_pkg::*;
(
  input  logic [LANE_W-1:0] la,
  input  logic [LANE_W-1:0] lb,
  output logic [LANE_W-1:0] res,
  output logic              ovfl
);

  logic [LANE_W-1:0] raw;

  // Wrapped sum, overflow when same-sign inputs produce a sum of the other sign.
  always_comb begin
    raw  = la + lb;
    ovfl = (la[LANE_W-1] == lb[LANE_W-1]) && (raw[LANE_W-1] != la[LANE_W-1]);
    res  = raw;
    if (ovfl) begin
      res = la[LANE_W-1] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/paddsb_seq.sv
// Multi-cycle packed saturating add: one lane adder walks the lanes, one per cycle.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid may not depend combinationally on ready, and once out_valid is
// raised sum/ovfl hold steady until the transfer completes.
module paddsb_seq
  import paddsb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    sum,
  output logic [LANES-1:0] ovfl,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    sum_q, sum_d;
  logic [LANES-1:0] ovfl_q, ovfl_d;

  logic [LANE_W-1:0] lane_a, lane_b, lane_res;
  logic              lane_ovfl;
  logic              accept;

  assign lane_a = a_q[int'(cnt_q)*LANE_W +: LANE_W];
  assign lane_b = b_q[int'(cnt_q)*LANE_W +: LANE_W];

  sat_lane_add u_lane (
    .la   (lane_a),
    .lb   (lane_b),
    .res  (lane_res),
    .ovfl (lane_ovfl)
  );

  // Ready is held low during reset so nothing is accepted while flops are cleared.
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign ovfl      = ovfl_q;

  // Next-state: accept operands, step one lane per cycle, hold result until retired.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovfl_d  = ovfl_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          ovfl_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(cnt_q)*LANE_W +: LANE_W] = lane_res;
        ovfl_d[cnt_q]                       = lane_ovfl;
        cnt_d                               = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LANES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Retire and start the next operation on the same edge.
            a_d     = a;
            b_d     = b;
            cnt_d   = '0;
            ovfl_d  = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovfl_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovfl_q  <= ovfl_d;
    end
  end

endmodule

// File: tb/tb_paddsb_seq.sv
// Bench for paddsb_seq: directed scenarios plus randomized operations,
// checked against a lane-by-lane clamping model and a result queue.
module tb_paddsb_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic [3:0]  ovfl;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [19:0] exp_q[$];

  paddsb_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovfl      (ovfl),
    .busy      (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each signed lane summed as an integer, then clamped to [-8, 7].
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    logic [3:0]  ov;
    logic [3:0]  nx, ny;
    int          s;
    r  = '0;
    ov = '0;
    for (int i = 0; i < 4; i++) begin
      nx = x[i*4 +: 4];
      ny = y[i*4 +: 4];
      s  = int'($signed(nx)) + int'($signed(ny));
      if (s > 7) begin
        s     = 7;
        ov[i] = 1'b1;
      end else if (s < -8) begin
        s     = -8;
        ov[i] = 1'b1;
      end
      r[i*4 +: 4] = 4'(s);
    end
    return {ov, r};
  endfunction

  // Scoreboard: record accepts, compare retires (sampled mid-cycle).
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          chk("sb_sum", 32'(sum), 32'(e[15:0]));
          chk("sb_ovfl", 32'(ovfl), 32'(e[19:16]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair from IDLE, wait for the result, optionally stall, then retire.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                        input int bp, input bit noise);
    logic [19:0] e;
    int n;
    e         = model(xa, xb);
    a         = xa;
    b         = xb;
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    #1;
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    n        = 0;
    while (!out_valid && n < 20) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = 16'($urandom);
        b        = 16'($urandom);
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'd4);
    chk("op_sum", 32'(sum), 32'(e[15:0]));
    chk("op_ovfl", 32'(ovfl), 32'(e[19:16]));
    for (int i = 0; i < bp; i++) begin
      #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_sum", 32'(sum), 32'(e[15:0]));
      chk("stall_ovfl", 32'(ovfl), 32'(e[19:16]));
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("retire_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("after_retire_valid", 32'(out_valid), 32'd0);
    chk("after_retire_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_ovfl", 32'(ovfl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    step();

    // No overflow, mixed saturation, backpressure on full negative saturation
    run_op(16'h1234, 16'h1111, 0, 1'b0);
    chk("idle_ready_after", 32'(in_ready), 32'd1);
    run_op(16'h783F, 16'h1F21, 0, 1'b0);
    run_op(16'h8888, 16'h8888, 3, 1'b0);

    // Ignored input during RUN
    run_op(16'h5A3C, 16'h2B7E, 1, 1'b1);

    // Back-to-back: second pair accepted on the retire edge
    a        = 16'h4321;
    b        = 16'h0F0F;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'd4);
    a        = 16'h0001;
    b        = 16'h0001;
    in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_no_bubble_busy", 32'(busy), 32'd1);
    chk("b2b_no_bubble_valid", 32'(out_valid), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("b2b_second_latency", 32'(n), 32'd4);
    chk("b2b_second_sum", 32'(sum), 32'h0002);
    chk("b2b_second_ovfl", 32'(ovfl), 32'h0);
    step();

    // Reset mid-RUN
    a        = 16'h7777;
    b        = 16'h7777;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_ovfl", 32'(ovfl), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk("postrst_no_stale", 32'(seen), 32'd0);

    // Randomized operations with random stalls and input noise
    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
